// File: rtl/bp_me_pkg.sv
// Shared message formats, tracker entry and error causes for the IO CCE.
// Widths are fixed per processor configuration; bp_paddr_mask trims addresses for smaller configs.
package bp_me_pkg;

  typedef enum logic {
    e_bp_inv_cfg     = 1'b0,
    e_bp_unicore_cfg = 1'b1
  } bp_params_e;

  localparam int lce_id_width_gp = 4;
  localparam int cce_id_width_gp = 4;
  localparam int paddr_width_gp  = 40;
  localparam int data_width_gp   = 64;
  localparam int size_width_gp   = 3;

  typedef enum logic [2:0] {
    e_lce_req_type_rd = 3'd0,
    e_lce_req_type_wr = 3'd1,
    e_lce_req_uc_rd   = 3'd2,
    e_lce_req_uc_wr   = 3'd3
  } bp_lce_cce_req_type_e;

  typedef enum logic [3:0] {
    e_lce_cmd_sync         = 4'd0,
    e_lce_cmd_set_clear    = 4'd1,
    e_lce_cmd_transfer     = 4'd2,
    e_lce_cmd_writeback    = 4'd3,
    e_lce_cmd_set_tag      = 4'd4,
    e_lce_cmd_invalidate   = 4'd5,
    e_lce_cmd_uc_data      = 4'd6,
    e_lce_cmd_uc_req_done  = 4'd7
  } bp_lce_cmd_type_e;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_type_e;

  typedef struct packed {
    bp_lce_cce_req_type_e        msg_type;
    logic [lce_id_width_gp-1:0]  src_id;
    logic [paddr_width_gp-1:0]   addr;
    logic [size_width_gp-1:0]    size;
    logic [data_width_gp-1:0]    data;
  } bp_lce_cce_req_s;

  typedef struct packed {
    bp_lce_cmd_type_e            msg_type;
    logic [lce_id_width_gp-1:0]  dst_id;
    logic [cce_id_width_gp-1:0]  src_id;
    logic [paddr_width_gp-1:0]   addr;
    logic [size_width_gp-1:0]    size;
    logic [data_width_gp-1:0]    data;
  } bp_lce_cmd_s;

  typedef struct packed {
    logic [lce_id_width_gp-1:0]  lce_id;
    logic [2:0]                  way_id;
    logic [2:0]                  state;
    logic                        uncached;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_type_e            msg_type;
    logic [paddr_width_gp-1:0]   addr;
    logic [size_width_gp-1:0]    size;
    bp_cce_mem_payload_s         payload;
    logic [data_width_gp-1:0]    data;
  } bp_cce_mem_msg_s;

  typedef struct packed {
    logic [lce_id_width_gp-1:0]  src_id;
    logic [paddr_width_gp-1:0]   addr;
    logic [size_width_gp-1:0]    size;
    logic                        wr;
  } bp_io_cce_track_entry_s;

  typedef enum logic [1:0] {
    e_io_err_addr     = 2'd0,
    e_io_err_type     = 2'd1,
    e_io_err_empty    = 2'd2,
    e_io_err_req_type = 2'd3
  } bp_io_err_e;

  localparam int io_err_num_gp = 4;

  // Unicore configuration only decodes a 39-bit physical space.
  function automatic logic [paddr_width_gp-1:0] bp_paddr_mask(bp_params_e cfg);
    logic [paddr_width_gp-1:0] mask;
    mask = '1;
    if (cfg == e_bp_unicore_cfg) mask = {1'b0, {(paddr_width_gp-1){1'b1}}};
    return mask;
  endfunction

endpackage

// File: rtl/bp_io_cce_tracked_if.sv
// LCE request/command and IO command/response channels of the tracked IO CCE.
// Signal suffixes are from the CCE's point of view; slave is the CCE, master the environment.
interface bp_io_cce_tracked_if;
  import bp_me_pkg::*;

  bp_lce_cce_req_s  lce_req_i;
  logic             lce_req_v_i;
  logic             lce_req_yumi_o;

  bp_lce_cmd_s      lce_cmd_o;
  logic             lce_cmd_v_o;
  logic             lce_cmd_ready_i;

  bp_cce_mem_msg_s  io_cmd_o;
  logic             io_cmd_v_o;
  logic             io_cmd_ready_i;

  bp_cce_mem_msg_s  io_resp_i;
  logic             io_resp_v_i;
  logic             io_resp_yumi_o;

  modport slave (
    input  lce_req_i, lce_req_v_i, output lce_req_yumi_o,
    output lce_cmd_o, lce_cmd_v_o, input  lce_cmd_ready_i,
    output io_cmd_o,  io_cmd_v_o,  input  io_cmd_ready_i,
    input  io_resp_i, io_resp_v_i, output io_resp_yumi_o
  );

  modport master (
    output lce_req_i, lce_req_v_i, input  lce_req_yumi_o,
    input  lce_cmd_o, lce_cmd_v_o, output lce_cmd_ready_i,
    input  io_cmd_o,  io_cmd_v_o,  output io_cmd_ready_i,
    output io_resp_i, io_resp_v_i, input  io_resp_yumi_o
  );

endinterface

// File: rtl/bp_io_cce_tracker.sv
// In-order tracker FIFO: head visible combinationally, push/pop take effect on the clock edge.
// ready_o depends only on occupancy, so a full tracker refuses a push even when popping.
module bp_io_cce_tracker #(
  parameter  int width_p  = 8,
  parameter  int els_p    = 4,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [width_p-1:0]  data_i,
  input  logic                v_i,
  output logic                ready_o,
  output logic [width_p-1:0]  data_o,
  output logic                v_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                push, pop;

  assign ready_o = (cnt_q != cnt_w_lp'(els_p));
  assign v_o     = (cnt_q != '0);
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wptr_d = wptr_q + ptr_w_lp'(push);
    rptr_d = rptr_q + ptr_w_lp'(pop);
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + cnt_w_lp'(1);
    else if (pop && !push) cnt_d = cnt_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_io_cce_tracked.sv
// Uncached IO CCE: LCE requests pass to IO in the same cycle; responses return as LCE commands 1 cycle later.
// Requests stall on full tracker or IO back-pressure; responses stall while the command register is held.
module bp_io_cce_tracked
  import bp_me_pkg::*;
#(
  parameter  bp_params_e bp_params_p      = e_bp_inv_cfg,
  parameter  int         io_outstanding_p = 4,
  localparam int         outstanding_w_lp = $clog2(io_outstanding_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [cce_id_width_gp-1:0]  cce_id_i,
  bp_io_cce_tracked_if.slave          io,
  output logic [outstanding_w_lp-1:0] outstanding_o,
  output logic                        err_o
);

  localparam int                        entry_w_lp    = $bits(bp_io_cce_track_entry_s);
  localparam logic [paddr_width_gp-1:0] paddr_mask_lp = bp_paddr_mask(bp_params_p);

  bp_lce_cce_req_s        req;
  bp_cce_mem_msg_s        resp, io_cmd;
  bp_lce_cmd_s            cmd_new, lce_cmd_d, lce_cmd_q;
  bp_io_cce_track_entry_s push_entry, head;
  logic                   trk_ready, trk_v;
  logic                   req_yumi, req_wr, req_legal;
  logic                   resp_yumi, resp_wr, obuf_space;
  logic                   lce_cmd_v_d, lce_cmd_v_q;
  logic                   err_d, err_q;
  logic [io_err_num_gp-1:0] err_hit;
  logic                   unused_bits;

  assign req       = io.lce_req_i;
  assign resp      = io.io_resp_i;
  assign req_wr    = (req.msg_type == e_lce_req_uc_wr);
  assign req_legal = req_wr | (req.msg_type == e_lce_req_uc_rd);
  assign resp_wr   = (resp.msg_type == e_cce_mem_uc_wr);

  // Reset gating keeps the request handshake quiet while the tracker is being cleared.
  assign req_yumi   = reset_n_i & io.lce_req_v_i & io.io_cmd_ready_i & trk_ready;
  assign obuf_space = ~lce_cmd_v_q | io.lce_cmd_ready_i;
  assign resp_yumi  = io.io_resp_v_i & trk_v & obuf_space;

  always_comb begin
    io_cmd                  = '0;
    io_cmd.msg_type         = req_wr ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
    io_cmd.addr             = req.addr & paddr_mask_lp;
    io_cmd.size             = req.size;
    io_cmd.data             = req.data;
    io_cmd.payload.lce_id   = req.src_id;
    io_cmd.payload.uncached = 1'b1;

    push_entry        = '0;
    push_entry.src_id = req.src_id;
    push_entry.addr   = req.addr & paddr_mask_lp;
    push_entry.size   = req.size;
    push_entry.wr     = req_wr;
  end

  bp_io_cce_tracker #(
    .width_p (entry_w_lp),
    .els_p   (io_outstanding_p)
  ) tracker (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (push_entry),
    .v_i       (req_yumi),
    .ready_o   (trk_ready),
    .data_o    (head),
    .v_o       (trk_v),
    .yumi_i    (resp_yumi),
    .count_o   (outstanding_o)
  );

  // Command type and destination always follow the tracker head, even if the response disagrees.
  always_comb begin
    cmd_new        = '0;
    cmd_new.dst_id = head.src_id;
    cmd_new.src_id = cce_id_i;
    cmd_new.addr   = resp.addr;
    if (head.wr) begin
      cmd_new.msg_type = e_lce_cmd_uc_req_done;
    end else begin
      cmd_new.msg_type = e_lce_cmd_uc_data;
      cmd_new.size     = resp.size;
      cmd_new.data     = resp.data;
    end

    lce_cmd_v_d = (lce_cmd_v_q & ~io.lce_cmd_ready_i) | resp_yumi;
    lce_cmd_d   = resp_yumi ? cmd_new : lce_cmd_q;
  end

  always_comb begin
    err_hit                    = '0;
    err_hit[e_io_err_addr]     = resp_yumi & ((resp.addr & paddr_mask_lp) != head.addr);
    err_hit[e_io_err_type]     = resp_yumi & (resp_wr != head.wr);
    err_hit[e_io_err_empty]    = io.io_resp_v_i & ~trk_v;
    err_hit[e_io_err_req_type] = req_yumi & ~req_legal;
    err_d                      = err_q | (|err_hit);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lce_cmd_q   <= '0;
      lce_cmd_v_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      lce_cmd_q   <= lce_cmd_d;
      lce_cmd_v_q <= lce_cmd_v_d;
      err_q       <= err_d;
    end
  end

  assign io.lce_req_yumi_o = req_yumi;
  assign io.io_cmd_o       = io_cmd;
  assign io.io_cmd_v_o     = req_yumi;
  assign io.io_resp_yumi_o = resp_yumi;
  assign io.lce_cmd_o      = lce_cmd_q;
  assign io.lce_cmd_v_o    = lce_cmd_v_q;
  assign err_o             = err_q;

  // Head size and response payload are tracked/transported but not needed to form the command.
  assign unused_bits = ^{head.size, resp.payload};

endmodule

// File: doc/bp_io_cce_tracked.md
BP_IO_CCE_TRACKED -- requirements
Module: bp_io_cce_tracked

Interface
REQ-001 Parameter bp_params_p, default e_bp_inv_cfg, selects the processor configuration and derives all LCE/CCE/mem widths.
REQ-002 Parameter io_outstanding_p, default 4, sets maximum in-flight IO requests; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk_i, input, 1 bit, the single clock.
REQ-005 Port reset_n_i, input, 1 bit, asynchronous active-low reset.
REQ-006 Port cce_id_i, input, cce_id_width_p bits, the identity of this CCE.
REQ-007 Ports lce_req_i, lce_req_v_i and lce_req_yumi_o: input lce_cce_req_width_lp, input 1, output 1; the LCE request channel.
REQ-008 Ports lce_cmd_o, lce_cmd_v_o and lce_cmd_ready_i: output lce_cmd_width_lp, output 1, input 1; the LCE command channel.
REQ-009 Ports io_cmd_o, io_cmd_v_o and io_cmd_ready_i: output cce_mem_msg_width_lp, output 1, input 1; the IO command channel.
REQ-010 Ports io_resp_i, io_resp_v_i and io_resp_yumi_o: input cce_mem_msg_width_lp, input 1, output 1; the IO response channel.
REQ-011 Port outstanding_o, output, clog2(io_outstanding_p+1) bits, the current in-flight request count.
REQ-012 Port err_o, output, 1 bit, sticky protocol-error flag.

Function
REQ-013 lce_req_yumi_o SHALL equal lce_req_v_i & io_cmd_ready_i & ~full, and io_cmd_v_o SHALL equal lce_req_yumi_o (zero latency).
REQ-014 io_cmd_o SHALL carry these fields: msg_type is e_cce_mem_uc_wr for a uc_wr request and e_cce_mem_uc_rd otherwise; addr, size and data are copied from the request; payload.lce_id is src_id; uncached is 1; every other field is 0.
REQ-015 On each accepted request, the block SHALL push {src_id, addr, size, wr} into an in-order tracker FIFO of depth io_outstanding_p.
REQ-016 When the tracker is full, no request SHALL be accepted in that cycle, even if a pop occurs in the same cycle.
REQ-017 io_resp_yumi_o SHALL equal io_resp_v_i & ~empty & obuf_space, where obuf_space = ~lce_cmd_v_o | lce_cmd_ready_i.
REQ-018 On each response yumi, the block SHALL pop the tracker head and register one LCE command; lce_cmd_v_o SHALL assert on the next cycle (1-cycle latency).
REQ-019 Back-to-back responses SHALL be sustained at one per cycle while lce_cmd_ready_i stays high.
REQ-020 The LCE command's dst_id SHALL come from the tracker head, not from the response payload.
REQ-021 The LCE command's src_id SHALL equal cce_id_i and its addr SHALL equal the response addr.
REQ-022 For a write head, the command SHALL be e_lce_cmd_uc_req_done with size 0 and data 0.
REQ-023 For a read head, the command SHALL be e_lce_cmd_uc_data with size and data taken from the response.
REQ-024 lce_cmd_o and lce_cmd_v_o SHALL hold stable while lce_cmd_v_o & ~lce_cmd_ready_i.
REQ-025 err_o SHALL set, and stay set until reset, on any of these events:
 - a response addr differs from the head addr;
 - a response write/read type differs from the head;
 - io_resp_v_i is high while the tracker is empty (the response is not consumed);
 - an accepted request type is neither uc_rd nor uc_wr (it is still issued as uc_rd).
REQ-026 On a mismatch, the command SHALL still be formed from the tracker head's type and dst_id.
REQ-027 outstanding_o SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop; it never wraps.
REQ-028 Tracker pointers SHALL wrap modulo io_outstanding_p, and full/empty SHALL be distinguished by the count.

Reset
REQ-029 While reset_n_i is low, asynchronously:
 - the tracker SHALL be emptied, with outstanding_o=0;
 - lce_cmd_v_o=0, lce_cmd_o=0, err_o=0;
 - lce_req_yumi_o, io_cmd_v_o and io_resp_yumi_o SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight entries; responses arriving afterwards SHALL be treated as empty-tracker errors.

Structure
REQ-031 The tracker entry struct and the error-cause enum SHALL be defined in bp_me_pkg.
REQ-032 The tracker FIFO SHALL be a sub-module named bp_io_cce_tracker, parametrised by entry width and depth, with ready/valid push and pop.

Verification
REQ-033 Single read: request uc_rd addr 0x8000_1000 from lce 1; response data 0xAB -> io_cmd uc_rd in the same cycle; one cycle after the response, uc_data with dst 1, src cce_id, data 0xAB.
REQ-034 Fill: 4 writes with io_resp_v_i held low -> outstanding_o=4; the 5th request is stalled; after one response, the 5th is accepted only in a later cycle.
REQ-035 Back-pressure: lce_cmd_ready_i low for 3 cycles with 2 responses pending -> 1 response consumed; lce_cmd_o stable; io_resp_yumi_o low; both delivered in order once ready rises.
REQ-036 Mismatch: head addr 0x100, response addr 0x140 -> err_o=1; the command still carries the head's dst_id.
REQ-037 Reset: assert reset_n_i low with 3 outstanding -> outstanding_o=0, lce_cmd_v_o=0, err_o=0 immediately; a subsequent response sets err_o and io_resp_yumi_o stays 0.
